// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: accepts one MULT/DIV request from the control unit,
// starts the selected iterative unit and waits for its done. On completion
// it steers the Hi/Lo source muxes and pulses the Hi/Lo writes. It also
// reports divide-by-zero, a sticky timeout, and busy.
module muldiv_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_is_div,
    input  logic [31:0] operand_b,
    input  logic        abort,
    output logic        op_ready,
    output logic        mult_start,
    input  logic        mult_done,
    output logic        div_start,
    input  logic        div_done,
    output logic        hi_src,
    output logic        lo_src,
    output logic        hi_write,
    output logic        lo_write,
    output logic        busy,
    output logic        done,
    output logic        dzero,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT_RUN,
        S_DIV_RUN,
        S_WB,
        S_DZERO,
        S_ERR
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_src;       // 1 = multiplier, 0 = divider

    logic w_run;
    logic w_accept;
    logic w_b_zero;
    logic w_unit_done;
    logic w_sampled_done;
    logic w_timeout_hit;

    assign w_run    = (r_state == S_MULT_RUN) || (r_state == S_DIV_RUN);
    assign w_accept = op_valid && (r_state == S_IDLE) && !abort;
    assign w_b_zero = (operand_b == 32'd0);

    // Only the selected unit's done matters; the other unit's done is ignored.
    assign w_unit_done    = (r_state == S_MULT_RUN) ? mult_done : div_done;
    // A done seen in the start cycle belongs to an earlier operation.
    assign w_sampled_done = w_unit_done && (r_cnt != '0);
    assign w_timeout_hit  = (r_cnt == CNT_W'(TIMEOUT));

    assign hi_src = r_src;
    assign lo_src = r_src;

    // Next-state selection and the state-decoded output pulses.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_next     = r_state;
        op_ready   = 1'b0;
        busy       = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        hi_write   = 1'b0;
        lo_write   = 1'b0;
        done       = 1'b0;
        dzero      = 1'b0;
        timeout    = 1'b0;

        case (r_state)
            S_IDLE: begin
                op_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept) begin
                    if (!op_is_div)    w_next = S_MULT_RUN;
                    else if (w_b_zero) w_next = S_DZERO;
                    else               w_next = S_DIV_RUN;
                end
            end
            S_MULT_RUN, S_DIV_RUN: begin
                mult_start = (r_state == S_MULT_RUN) && (r_cnt == '0);
                div_start  = (r_state == S_DIV_RUN)  && (r_cnt == '0);
                // Abort discards even a coincident done; done beats timeout.
                if (abort)               w_next = S_IDLE;
                else if (w_sampled_done) w_next = S_WB;
                else if (w_timeout_hit)  w_next = S_ERR;
            end
            S_WB: begin
                hi_write = 1'b1;
                lo_write = 1'b1;
                done     = 1'b1;
                w_next   = S_IDLE;
            end
            S_DZERO: begin
                dzero  = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                timeout = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register; ERR is left only through reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // RUN cycle counter: cleared on acceptance, counts every RUN cycle.
    always_ff @(posedge clk) begin
        if (reset)         r_cnt <= '0;
        else if (w_accept) r_cnt <= '0;
        else if (w_run)    r_cnt <= r_cnt + CNT_W'(1);
    end

    // Hi/Lo source selection, latched only by an accepted MULT or real DIV.
    always_ff @(posedge clk) begin
        if (reset)
            r_src <= 1'b0;
        else if (w_accept && !(op_is_div && w_b_zero))
            r_src <= !op_is_div;
    end

endmodule
